alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Command-level controller for the W-bit ALU slice array (per-bit result mux + add/sub + shifters).
//  Accepts one op per valid/ready handshake and drives ALU select/operands. Shifts run as repeated 1-bit steps.
//  Captures the ALU result into an accumulator and returns it on a valid/ready response port.
//  Sits between the instruction/command source and the combinational ALU; one op in flight at a time.
// PARAMETERS
//  WIDTH  8  datapath width (bits of a, b, result)
//  CNT_W  3  shift-count width; max shift = 2**CNT_W-1
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept (IDLE only)
//  cmd_op     in   4      ALU select code (encoding below)
//  cmd_a      in   WIDTH  operand A / value to shift
//  cmd_b      in   WIDTH  operand B (ignored for shifts)
//  cmd_cnt    in   CNT_W  shift amount (ignored for non-shifts)
//  flush      in   1      sync abort: return to IDLE, drop op/response
//  alu_select out  4      select lines to ALU slices
//  alu_a      out  WIDTH  ALU operand A (= accumulator)
//  alu_b      out  WIDTH  ALU operand B
//  alu_result in   WIDTH  combinational ALU result
//  alu_cout   in   1      adder carry/borrow out
//  rsp_valid  out  1      result available
//  rsp_ready  in   1      consumer takes result
//  rsp_data   out  WIDTH  result
//  rsp_zero   out  1      rsp_data == 0
//  rsp_cout   out  1      carry captured on add/sub; 0 otherwise
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Op encoding: 1xx0 add, 1xx1 sub; 01x0 shl 1, 01x1 shr 1 (zero fill); 0000 AND; 0001 OR; 001x XNOR.
//  Reset (async, rst_n=0): state IDLE.
//   Outputs cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_cout=0, alu_select=0, alu_a=0, alu_b=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: cmd_ready=1. On clock edge with cmd_valid && cmd_ready, latch op, acc<=cmd_a, b_reg<=cmd_b.
//   Remaining-count register rem<=cmd_cnt for shifts, 1 otherwise.
//   Shift with cmd_cnt==0 goes directly to DONE with rsp_data=cmd_a. All other ops go to RUN.
//  RUN: alu_select=op, alu_a=acc, alu_b=b_reg.
//   Each edge: acc<=alu_result, rem<=rem-1. When rem==1, go to DONE.
//   On that same edge, capture rsp_cout = add/sub ? alu_cout : 0.
//   Non-shift ops spend 1 RUN cycle. Shift by n spends n RUN cycles.
//  DONE: rsp_valid=1, rsp_data=acc, rsp_zero=(acc==0); alu_select=0.
//   rsp_data and flags are held stable until rsp_valid && rsp_ready, then IDLE.
//   cmd_ready=0 in DONE: no accept/respond overlap.
//  Latency, handshake edge to rsp_valid high: 2 clk for non-shift, n+1 for shift n>=1, 1 for shift n=0.
//  cmd_valid outside IDLE is ignored. The requester must hold the command until cmd_ready.
//  flush=1 on any edge forces IDLE and rsp_valid=0. acc is not cleared. flush wins over a same-edge handshake.
//  An async reset mid-RUN or mid-DONE discards the op. No response is ever issued for it.
//  Shift ops never cross accumulator width: zero fill means shift >= WIDTH yields 0.
//  Add/sub wraps modulo 2**WIDTH. Carry/borrow is reported only through rsp_cout.
// TESTING (bench models ALU slices behaviourally; WIDTH=8)
//  AND a=F0 b=3C: rsp_data=30, rsp_valid 2 clk after handshake, rsp_zero=0.
//  SUB a=05 b=07: rsp_data=FE, rsp_cout=borrow per adder model.
//  ADD a=FF b=01: rsp_data=00, rsp_zero=1, rsp_cout=1.
//  SHL a=81 cnt=3: alu_select=0100 for exactly 3 clk, rsp_data=08, rsp_valid 4 clk after handshake.
//   SHR a=81 cnt=7: rsp_data=01. Shift cnt=0 a=5A: rsp_data=5A after 1 clk.
//  Backpressure: hold rsp_ready=0 10 clk in DONE: rsp_valid/rsp_data stable, cmd_ready=0.
//   A second cmd_valid is not taken. It is accepted on the edge after the rsp_ready handshake.
//  Abort: rst_n low during 2nd RUN cycle of SHL cnt=5 -> all outputs at reset values immediately.
//   flush in RUN -> IDLE next edge, no rsp_valid pulse.
//   Next command AND a=FF b=0F -> 0F.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command-level controller for a combinational W-bit ALU slice array.
//   Takes one op per cmd valid/ready handshake, drives the ALU select and
//   operand lines, and runs shifts as repeated 1-bit ALU steps. The result
//   is held in an accumulator and returned on the rsp valid/ready port.
//   Only one op is in flight at a time.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/a/b/cnt        ALU select code, operands, shift amount
//   flush                 synchronous abort back to IDLE
//   alu_select/a/b        drive lines to the ALU slices (zero unless RUN)
//   alu_result/alu_cout   combinational ALU result and adder carry/borrow
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/zero/cout    result, zero flag, carry captured on add/sub
//   busy                  high whenever the sequencer is not IDLE
//
// Op encoding: 1xx0 add, 1xx1 sub, 01x0 shl 1, 01x1 shr 1, 0000 AND,
// 0001 OR, 001x XNOR.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             flush,
    output logic [3:0]       alu_select,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [3:0]       op_reg, op_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic             cout_reg, cout_next;

    logic cmd_is_shift;
    assign cmd_is_shift = (cmd_op[3:2] == 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            acc_reg   <= '0;
            b_reg     <= '0;
            rem_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            acc_reg   <= acc_next;
            b_reg     <= b_next;
            rem_reg   <= rem_next;
            cout_reg  <= cout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        acc_next   = acc_reg;
        b_next     = b_reg;
        rem_next   = rem_reg;
        cout_next  = cout_reg;

        if (flush) begin
            // Abort beats everything, including a same-edge command accept;
            // the accumulator keeps whatever it held.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_next   = cmd_op;
                        acc_next  = cmd_a;
                        b_next    = cmd_b;
                        cout_next = 1'b0;
                        if (cmd_is_shift) begin
                            rem_next   = cmd_cnt;
                            // A zero-length shift has nothing to run.
                            state_next = (cmd_cnt == '0) ? DONE : RUN;
                        end else begin
                            rem_next   = REM_ONE;
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    acc_next = alu_result;
                    rem_next = rem_reg - REM_ONE;
                    if (rem_reg == REM_ONE) begin
                        state_next = DONE;
                        cout_next  = op_reg[3] ? alu_cout : 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ALU lines are only driven while stepping; otherwise parked at zero.
    assign alu_select = (state_reg == RUN) ? op_reg  : 4'd0;
    assign alu_a      = (state_reg == RUN) ? acc_reg : '0;
    assign alu_b      = (state_reg == RUN) ? b_reg   : '0;

    assign cmd_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign rsp_valid  = (state_reg == DONE);
    assign rsp_data   = (state_reg == DONE) ? acc_reg : '0;
    assign rsp_zero   = (state_reg == DONE) && (acc_reg == '0);
    assign rsp_cout   = (state_reg == DONE) && cout_reg;

endmodule
